// File: rtl/timing_control_unit_if.sv
// Bus between the timing control unit and the sequence counter / datapath.
// The master side drives T, the instruction word and start; the slave side returns the strobes.
interface timing_control_unit_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 12
);
    logic [1:0]        t_in;
    logic [WORD_W-1:0] ir_in;
    logic              start;
    logic              freeze;
    logic [3:0]        t_dec;
    logic              ar_load;
    logic              ir_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] addr_out;
    logic              acc_ld;
    logic              acc_add;
    logic              acc_and;
    logic              mem_wr;
    logic              pc_ld;
    logic              acc_clr;
    logic              halted;
    logic              seq_err;

    modport master (
        output t_in, ir_in, start,
        input  freeze, t_dec, ar_load, ir_load, pc_inc, addr_out,
        input  acc_ld, acc_add, acc_and, mem_wr, pc_ld, acc_clr, halted, seq_err
    );

    modport slave (
        input  t_in, ir_in, start,
        output freeze, t_dec, ar_load, ir_load, pc_inc, addr_out,
        output acc_ld, acc_add, acc_and, mem_wr, pc_ld, acc_clr, halted, seq_err
    );
endinterface

// File: rtl/timing_control_unit.sv
// Basic-computer timing control: run/halt FSM plus T-phase strobes for fetch, decode and execute.
// Define TCU_SEQ_CHECK_EN to build the sticky T-sequence checker (seq_err); otherwise seq_err is 0.
module timing_control_unit #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    timing_control_unit_if.slave bus
);
    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] addr_q;
    logic              freeze_q;
    logic              halted_q;

    logic [3:0] t_dec_c;
    logic       ar_load_c;
    logic       ir_load_c;
    logic       pc_inc_c;
    logic       acc_ld_c;
    logic       acc_add_c;
    logic       acc_and_c;
    logic       mem_wr_c;
    logic       pc_ld_c;
    logic       acc_clr_c;

    // State register; freeze and halted are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            freeze_q <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            freeze_q <= (state_nxt != ST_RUN);
            halted_q <= (state_nxt == ST_HALT);
        end
    end

    // Decode phase: latch opcode and address at the edge ending T2
    always_ff @(posedge clk) begin
        if (!rst) begin
            opcode <= '0;
            addr_q <= '0;
        end else if (state == ST_RUN && bus.t_in == 2'd2) begin
            opcode <= bus.ir_in[WORD_W-1 -: OP_W];
            addr_q <= bus.ir_in[ADDR_W-1:0];
        end
    end

    // Next state and zero-latency phase strobes
    always_comb begin
        state_nxt = state;
        t_dec_c   = 4'(1) << bus.t_in;
        ar_load_c = 1'b0;
        ir_load_c = 1'b0;
        pc_inc_c  = 1'b0;
        acc_ld_c  = 1'b0;
        acc_add_c = 1'b0;
        acc_and_c = 1'b0;
        mem_wr_c  = 1'b0;
        pc_ld_c   = 1'b0;
        acc_clr_c = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (bus.start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                case (bus.t_in)
                    2'd0: ar_load_c = 1'b1;
                    2'd1: begin
                        ir_load_c = 1'b1;
                        pc_inc_c  = 1'b1;
                    end
                    2'd3: begin
                        case (opcode)
                            3'b001:  acc_ld_c  = 1'b1;
                            3'b010:  acc_add_c = 1'b1;
                            3'b011:  acc_and_c = 1'b1;
                            3'b100:  mem_wr_c  = 1'b1;
                            3'b101:  pc_ld_c   = 1'b1;
                            3'b110:  acc_clr_c = 1'b1;
                            3'b111:  state_nxt = ST_HALT;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.freeze   = freeze_q;
    assign bus.halted   = halted_q;
    assign bus.addr_out = addr_q;
    assign bus.t_dec    = t_dec_c;
    assign bus.ar_load  = ar_load_c;
    assign bus.ir_load  = ir_load_c;
    assign bus.pc_inc   = pc_inc_c;
    assign bus.acc_ld   = acc_ld_c;
    assign bus.acc_add  = acc_add_c;
    assign bus.acc_and  = acc_and_c;
    assign bus.mem_wr   = mem_wr_c;
    assign bus.pc_ld    = pc_ld_c;
    assign bus.acc_clr  = acc_clr_c;

`ifdef TCU_SEQ_CHECK_EN
    logic [1:0] exp_t;
    logic       seq_err_q;

    // Expected T advances with the counter while running; any disagreement is sticky
    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_t     <= 2'd0;
            seq_err_q <= 1'b0;
        end else if (state == ST_RUN) begin
            exp_t <= exp_t + 2'd1;
            if (bus.t_in != exp_t) seq_err_q <= 1'b1;
        end else begin
            exp_t <= 2'd0;
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    assign bus.seq_err = 1'b0;
`endif
endmodule

// File: doc/timing_control_unit.md
# timing_control_unit

- Control stage directly downstream of the 2-bit sequence counter in the basic-computer datapath.
- Consumes the counter's timing value T[1:0] and the fetched instruction word, and produces per-phase datapath strobes (fetch, decode, execute).
- Drives the counter's freeze input back, holding T while the machine is idle or halted.
- Also runs a run/halt state machine and, optionally, a sequence-integrity checker.

## Interface
Parameters:
- WORD_W, 16: instruction word width; opcode is ir_in[WORD_W-1:WORD_W-3]; WORD_W >= ADDR_W+3.
- ADDR_W, 12: address field width, ir_in[ADDR_W-1:0].

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (reset when rst==0 at a rising edge of clk).
- t_in  in  2  current timing value T from the sequence counter.
- ir_in  in  WORD_W  instruction register contents.
- start  in  1  level; leaves IDLE/HALT.
- freeze  out  1  to sequence counter E; 1 holds T.
- t_dec  out  4  one-hot decode of t_in, ungated: t_dec[i]=1 when t_in==i.
- ar_load  out  1  AR <- PC.
- ir_load  out  1  IR <- M[AR].
- pc_inc  out  1  PC <- PC+1.
- addr_out  out  ADDR_W  latched address field.
- acc_ld  out  1  ACC <- M[addr].
- acc_add  out  1  ACC <- ACC + M[addr].
- acc_and  out  1  ACC <- ACC & M[addr].
- mem_wr  out  1  M[addr] <- ACC.
- pc_ld  out  1  PC <- addr.
- acc_clr  out  1  ACC <- 0.
- halted  out  1  state==HALT.
- seq_err  out  1  sticky timing-mismatch flag.

## Operation
State machine (registered): IDLE, RUN, HALT.
- IDLE: entered on reset. start==1 -> RUN.
- RUN: HLT executed at T3 -> HALT. start is ignored.
- HALT: start==1 -> RUN.
- freeze = 1 in IDLE and HALT, 0 in RUN.

Strobes: combinational from t_in and registered state/opcode; all strobes are 0 unless state==RUN.
- T0: ar_load=1.
- T1: ir_load=1, pc_inc=1.
- T2 (decode): opcode register <= ir_in[WORD_W-1:WORD_W-3]; addr_out <= ir_in[ADDR_W-1:0]; both captured at the edge ending T2. No strobes during T2.
- T3 (execute), decoded from the latched opcode:
  - 000 NOP: none
  - 001 LDA: acc_ld
  - 010 ADD: acc_add
  - 011 AND: acc_and
  - 100 STA: mem_wr
  - 101 JMP: pc_ld
  - 110 CLA: acc_clr
  - 111 HLT: no strobe; state -> HALT at the edge ending T3.
- At most one execute strobe is high in any cycle.

Sequence check (when compiled in):
- Register exp_t tracks the expected T.
- Held at 0 outside RUN; in RUN, exp_t <= exp_t+1 (mod 4) each cycle.
- In RUN, t_in != exp_t sets seq_err; it stays 1 until reset. No effect on sequencing.

Reset values:
- state=IDLE, opcode=000, addr_out=0, exp_t=0, seq_err=0, halted=0.
- freeze=1; all strobes 0; t_dec follows t_in.

## Timing
- Strobes are valid in the same cycle as the corresponding t_in (zero latency). The datapath captures them at the edge ending that cycle.
- start sampled 1 in IDLE: RUN from the next cycle, freeze drops, and the counter begins advancing from T0.
- HLT: the counter sees freeze=0 at the edge ending T3 and wraps to 0. The block enters HALT at that same edge, so T is held at 0. Resume on start fetches at T0, PC already incremented past HLT.
- Reset mid-instruction: state is IDLE from the next cycle; strobes drop; the latched opcode is cleared. The sequence counter is reset by the same rst.
- Simultaneous start and rst==0: reset wins.
- start held high continuously in RUN: no effect.

## Configuration
- TCU_SEQ_CHECK_EN defined: exp_t register and seq_err logic are present as described.
- TCU_SEQ_CHECK_EN undefined: no exp_t register; seq_err is tied to 0; all other behaviour is identical.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then start=0 for 5 cycles -> freeze=1, halted=0, all strobes 0, seq_err=0.
- ADD at 0x123: start=1 one cycle, ir_in=0x4123 (WORD_W=16) -> T0 ar_load; T1 ir_load+pc_inc; T3 acc_add=1 only; addr_out=0x123 from T3.
- HLT: ir_in=0xE000 -> no execute strobe at T3; halted=1 and freeze=1 from the next cycle with t_in held at 0. A start pulse resumes and ar_load asserts on the next T0.
- Opcode sweep 000..111: each opcode yields exactly its listed T3 strobe (NOP none, CLA acc_clr, JMP pc_ld, STA mem_wr).
- Sequence error (macro defined): in RUN, force t_in 0 -> 2 skipping 1 -> seq_err=1 next cycle and held through HALT; cleared only by rst=0. With the macro undefined, seq_err stays 0.
- Reset at T3 of STA: mem_wr deasserts the cycle after the reset edge; state=IDLE; addr_out=0.
